// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults (640x480@60), counter width, sync polarity and
// the window decode helper used by the per-axis flag generators.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// Single-axis wrap counter with a registered [start,end] pulse; the pulse is
// decoded from the next count so it lines up with o_cnt in the same cycle.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned TOTAL   = 800,
  parameter int unsigned P_START = 656,
  parameter int unsigned P_END   = 751,
  parameter logic        ACTIVE  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output cnt_t o_cnt,
  output cnt_t o_next,
  output logic o_wrap,
  output logic o_pulse
);

  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t W_START = cnt_t'(P_START);
  localparam cnt_t W_END   = cnt_t'(P_END);

  cnt_t r_cnt;
  logic r_pulse;
  cnt_t w_next;
  logic w_wrap;

  always_comb begin
    w_wrap = i_en && (r_cnt == LAST);
    w_next = r_cnt;
    if (i_en) begin
      w_next = (r_cnt == LAST) ? '0 : r_cnt + cnt_t'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_pulse <= ~ACTIVE;
    end else if (i_en) begin
      r_cnt   <= w_next;
      r_pulse <= in_window(w_next, W_START, W_END) ? ACTIVE : ~ACTIVE;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_next  = w_next;
  assign o_wrap  = w_wrap;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, syncs and blanking flags.
// Define VGA_FRAME_CNT_EN to build the free-running 8-bit frame counter.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam cnt_t        H_VIS   = cnt_t'(H_DISPLAY);
  localparam cnt_t        V_VIS   = cnt_t'(V_DISPLAY);

  cnt_t w_h_next;
  cnt_t w_v_next;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_v_en;
  logic r_display_on;
  logic r_line_start;
  logic r_frame_start;

  assign w_v_en = ce & w_h_wrap;

  vga_axis_counter #(
    .TOTAL  (H_TOTAL),
    .P_START(H_DISPLAY + H_FRONT),
    .P_END  (H_DISPLAY + H_FRONT + H_SYNC - 1),
    .ACTIVE (SYNC_ACTIVE)
  ) u_h_axis (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (ce),
    .o_cnt  (pix_x),
    .o_next (w_h_next),
    .o_wrap (w_h_wrap),
    .o_pulse(hsync)
  );

  vga_axis_counter #(
    .TOTAL  (V_TOTAL),
    .P_START(V_DISPLAY + V_FRONT),
    .P_END  (V_DISPLAY + V_FRONT + V_SYNC - 1),
    .ACTIVE (SYNC_ACTIVE)
  ) u_v_axis (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (w_v_en),
    .o_cnt  (pix_y),
    .o_next (w_v_next),
    .o_wrap (w_v_wrap),
    .o_pulse(vsync)
  );

  // A wrap strobe is exactly "next count is zero", so the start pulses reuse it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_display_on  <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a reduced-timing instance (16x12 raster)
// tracked by a counter model, plus a default 640x480 instance for line timing.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_n;
  logic       ce;

  logic [9:0] pix_x, pix_y;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [7:0] frame_cnt;

  logic [9:0] d_pix_x, d_pix_y;
  logic       d_hsync, d_vsync, d_display_on, d_line_start, d_frame_start;
  logic [7:0] d_frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the reduced instance
  int mx, my, mfc, model_bad;
  bit m_fresh;

  int hs_low, hs_first, hs_last, de_cnt, overlap, bad, vs_low, fs_cnt, ls_cnt;
  int ls_ce, ls_clk, fs_seen, seq_bad, zero_at_fs;
  logic [7:0] exp_fc;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen u_dut_def (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pix_x(d_pix_x), .pix_y(d_pix_y), .hsync(d_hsync), .vsync(d_vsync),
    .display_on(d_display_on), .line_start(d_line_start),
    .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mfc = 0; m_fresh = 1'b1;
  endtask

  task automatic model_step();
    m_fresh = 1'b0;
    mx++;
    if (mx == 16) begin
      mx = 0;
      my++;
      if (my == 12) begin
        my = 0;
        mfc = (mfc + 1) % 256;
      end
    end
  endtask

  task automatic model_compare();
    logic e_hs, e_vs, e_de, e_ls, e_fs;
    logic [7:0] e_fc;
    e_hs = !(mx >= 10 && mx <= 12);
    e_vs = !(my >= 8 && my <= 9);
    e_de = !m_fresh && (mx < 8) && (my < 6);
    e_ls = !m_fresh && (mx == 0);
    e_fs = !m_fresh && (mx == 0) && (my == 0);
`ifdef VGA_FRAME_CNT_EN
    e_fc = 8'(mfc);
`else
    e_fc = 8'd0;
`endif
    if (pix_x !== 10'(mx) || pix_y !== 10'(my) || hsync !== e_hs || vsync !== e_vs ||
        display_on !== e_de || line_start !== e_ls || frame_start !== e_fs ||
        frame_cnt !== e_fc)
      model_bad++;
  endtask

  task automatic tick(input logic c);
    ce = c;
    @(posedge clk);
    if (rst_n && c) model_step();
    #1;
    model_compare();
  endtask

  initial begin
    model_bad = 0;
    rst_n = 1'b0;
    ce = 1'b0;
    model_reset();
    repeat (3) tick(1'b0);

    // reset state
    check_eq("rst_pix_x", 32'(pix_x), 0);
    check_eq("rst_pix_y", 32'(pix_y), 0);
    check_eq("rst_hsync", 32'(hsync), 1);
    check_eq("rst_vsync", 32'(vsync), 1);
    check_eq("rst_display_on", 32'(display_on), 0);
    check_eq("rst_line_start", 32'(line_start), 0);
    check_eq("rst_frame_start", 32'(frame_start), 0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("rst_def_pix_x", 32'(d_pix_x), 0);
    check_eq("rst_def_hsync", 32'(d_hsync), 1);
    check_eq("rst_def_vsync", 32'(d_vsync), 1);
    check_eq("rst_def_display_on", 32'(d_display_on), 0);
    check_eq("rst_def_frame_start", 32'(d_frame_start), 0);
    check_eq("rst_def_frame_cnt", 32'(d_frame_cnt), 0);

    // first step after release
    rst_n = 1'b1;
    tick(1'b1);
    check_eq("first_pix_x", 32'(pix_x), 1);
    check_eq("first_pix_y", 32'(pix_y), 0);
    check_eq("first_display_on", 32'(display_on), 1);
    check_eq("first_line_start", 32'(line_start), 0);
    check_eq("first_frame_start", 32'(frame_start), 0);
    check_eq("first_def_pix_x", 32'(d_pix_x), 1);
    check_eq("first_def_display_on", 32'(d_display_on), 1);

    // one default line: x=2..799, then wrap to 0 on line 1
    hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0; overlap = 0; bad = 0;
    for (int i = 0; i < 799; i++) begin
      tick(1'b1);
      if (32'(d_pix_x) != (i + 2) % 800) bad++;
      if (!d_hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = 32'(d_pix_x);
        hs_last = 32'(d_pix_x);
      end
      if (d_display_on) de_cnt++;
      if (d_display_on && !d_hsync) overlap++;
    end
    check_eq("def_pix_x_seq", 32'(bad), 0);
    check_eq("def_hsync_low_len", 32'(hs_low), 96);
    check_eq("def_hsync_first_x", 32'(hs_first), 656);
    check_eq("def_hsync_last_x", 32'(hs_last), 751);
    check_eq("def_display_cnt", 32'(de_cnt), 639);
    check_eq("def_display_hsync_overlap", 32'(overlap), 0);
    check_eq("def_wrap_pix_x", 32'(d_pix_x), 0);
    check_eq("def_wrap_pix_y", 32'(d_pix_y), 1);
    check_eq("def_wrap_line_start", 32'(d_line_start), 1);
    check_eq("def_wrap_frame_start", 32'(d_frame_start), 0);
    check_eq("def_vsync_line1", 32'(d_vsync), 1);

    // 800 steps on the 16x12 raster land at (0,2)
    check_eq("small_pos_x", 32'(pix_x), 0);
    check_eq("small_pos_y", 32'(pix_y), 2);
    check_eq("small_line_start", 32'(line_start), 1);

    // ce alternating 1,0: one line takes 32 clocks
    ls_ce = 0; ls_clk = 0;
    for (int k = 0; k < 32; k++) begin
      tick((k % 2) == 0);
      if (k == 0) check_eq("ce_tog_step", 32'(pix_x), 1);
      if (k == 1) check_eq("ce_tog_hold", 32'(pix_x), 1);
      if (k == 2) check_eq("ce_tog_step2", 32'(pix_x), 2);
      if ((k % 2) == 0 && line_start) ls_ce++;
      if (line_start) ls_clk++;
    end
    check_eq("ce_tog_line_start_ce_cycles", 32'(ls_ce), 1);
    check_eq("ce_tog_line_start_clk_cycles", 32'(ls_clk), 2);
    check_eq("ce_tog_end_x", 32'(pix_x), 0);
    check_eq("ce_tog_end_y", 32'(pix_y), 3);

    // run into both sync pulses, then reset asynchronously
    repeat (91) tick(1'b1);
    check_eq("mid_pix_x", 32'(pix_x), 11);
    check_eq("mid_pix_y", 32'(pix_y), 8);
    check_eq("mid_hsync", 32'(hsync), 0);
    check_eq("mid_vsync", 32'(vsync), 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("mid_frame_cnt", 32'(frame_cnt), 4);
`else
    check_eq("mid_frame_cnt", 32'(frame_cnt), 0);
`endif
    rst_n = 1'b0;
    model_reset();
    #2;
    model_compare();
    check_eq("arst_pix_x", 32'(pix_x), 0);
    check_eq("arst_pix_y", 32'(pix_y), 0);
    check_eq("arst_hsync", 32'(hsync), 1);
    check_eq("arst_vsync", 32'(vsync), 1);
    check_eq("arst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("arst_def_pix_x", 32'(d_pix_x), 0);
    check_eq("arst_def_pix_y", 32'(d_pix_y), 0);
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
    tick(1'b1);
    check_eq("restart_pix_x", 32'(pix_x), 1);
    check_eq("restart_pix_y", 32'(pix_y), 0);
    check_eq("restart_display_on", 32'(display_on), 1);

    // one full small frame, (2,0) through (1,0) of the next frame
    de_cnt = 0; vs_low = 0; fs_cnt = 0; ls_cnt = 0; overlap = 0;
    for (int i = 0; i < 192; i++) begin
      tick(1'b1);
      if (display_on) de_cnt++;
      if (!vsync) vs_low++;
      if (frame_start) begin
        fs_cnt++;
        check_eq("frame_start_pos", 32'({pix_y, pix_x}), 0);
      end
      if (line_start) ls_cnt++;
      if (display_on && (!hsync || !vsync)) overlap++;
    end
    check_eq("frame_display_cnt", 32'(de_cnt), 48);
    check_eq("frame_vsync_low", 32'(vs_low), 32);
    check_eq("frame_start_cnt", 32'(fs_cnt), 1);
    check_eq("frame_line_start_cnt", 32'(ls_cnt), 12);
    check_eq("frame_display_sync_overlap", 32'(overlap), 0);
    check_eq("frame_end_frame_start", 32'(frame_start), 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("frame_cnt_after_1", 32'(frame_cnt), 1);
`else
    check_eq("frame_cnt_after_1", 32'(frame_cnt), 0);
`endif

    // 256 more frames: frame_cnt wraps back to its starting value
    fs_seen = 0; seq_bad = 0; zero_at_fs = 0;
    for (int i = 0; i < 256 * 192; i++) begin
      tick(1'b1);
      if (frame_start) begin
        fs_seen++;
`ifdef VGA_FRAME_CNT_EN
        exp_fc = 8'((1 + fs_seen) % 256);
`else
        exp_fc = 8'd0;
`endif
        if (frame_cnt !== exp_fc) seq_bad++;
        if (frame_cnt == 8'd0) zero_at_fs++;
      end
    end
    check_eq("frames_seen", 32'(fs_seen), 256);
    check_eq("frame_cnt_sequence", 32'(seq_bad), 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("frame_cnt_zero_hits", 32'(zero_at_fs), 1);
    check_eq("frame_cnt_final", 32'(frame_cnt), 1);
`else
    check_eq("frame_cnt_zero_hits", 32'(zero_at_fs), 256);
    check_eq("frame_cnt_final", 32'(frame_cnt), 0);
`endif
    check_eq("model_tracking", 32'(model_bad), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
